sibling_rr_arbiter: RTL



---
 rtl/sibling_arb_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 36 +++
 rtl/sibling_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/sibling_arb_pkg.sv
// Shared types and default sizing for the sibling round-robin arbiter.
package sibling_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N_REQ    = 5;
    localparam int ARB_HOLD_MAX = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: returns the first set request at or after ptr,
// wrapping from the top index back to 0. Purely combinational.
module rr_priority_pick #(
    parameter int N_REQ = 5
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] id
);

    localparam int IW = $clog2(N_REQ);
    // One extra bit so ptr + offset never overflows before the wrap compare.
    localparam int SW = IW + 1;
    localparam logic [SW-1:0] N_W = SW'(N_REQ);

    logic [SW-1:0] w_sum;

    // Scan offsets 0..N_REQ-1 from ptr and keep the first hit.
    always_comb begin
        any   = 1'b0;
        id    = '0;
        w_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, ptr} + SW'(k);
            if (w_sum >= N_W) begin
                w_sum = w_sum - N_W;
            end
            if (!any && req[w_sum[IW-1:0]]) begin
                any = 1'b1;
                id  = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/sibling_rr_arbiter.sv
// Round-robin arbiter sharing one downstream resource among sibling leaves.
// A grant is held until the leaf completes or withdraws, or until the hold
// limit forces it off.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; pick next requester from ptr when any req is set
// GRANT | one leaf owns the resource; hold_cnt counts granted cycles
module sibling_rr_arbiter
    import sibling_arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int HOLD_MAX = ARB_HOLD_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IW-1:0]    r_gnt_id;
    logic             r_busy;
    logic             r_timeout;
    logic [IW-1:0]    r_ptr;
    logic [CW-1:0]    r_hold_cnt;

    logic             w_any;
    logic [IW-1:0]    w_id;
    logic             w_done_g;
    logic             w_req_g;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .id  (w_id)
    );

    // Only the granted leaf's done/req bits can end a grant.
    assign w_done_g = done[r_gnt_id];
    assign w_req_g  = req[r_gnt_id];

    // Arbitration FSM with registered grant, status and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state    <= GRANT;
                        r_gnt      <= N_REQ'(1) << w_id;
                        r_gnt_id   <= w_id;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= '0;
                        // Explicit wrap so non-power-of-two N_REQ rotates correctly.
                        r_ptr      <= (w_id == LAST_ID) ? '0 : w_id + 1'b1;
                    end
                end
                GRANT: begin
                    if (w_done_g || !w_req_g) begin
                        // Completion beats the hold limit when both hit together.
                        r_state   <= IDLE;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b0;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= IDLE;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
